// File: rtl/spi_seq_pkg.sv
// Shared types and register map for the SPI burst sequencer.
package spi_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_TX,
        ST_WR_DATA,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_DATA,
        ST_RX,
        ST_RELEASE
    } state_t;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_TXD  = 2'd1;
    localparam logic [1:0] ADDR_RXD  = 2'd2;

    localparam int CTRL_GO     = 7;
    localparam int CTRL_SS_LSB = 3;
    localparam int CTRL_SS_MSB = 6;
    localparam int BUSY_BIT    = 7;

    // Control word that starts a transfer with the given slave select driven
    function automatic logic [15:0] ctrl_word(input logic [3:0] ss);
        logic [15:0] w;
        w = '0;
        w[CTRL_GO] = 1'b1;
        w[CTRL_SS_MSB:CTRL_SS_LSB] = ss;
        return w;
    endfunction

endpackage

// File: rtl/spi_burst_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // last = 1 means req1 was served most recently (reset value gives req0 the first tie)
    logic last;

    // One-hot grant from the current requests and the pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Move the pointer to whoever was just granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (advance && (|req))
            last <= gnt[1];
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Burst front end: arbitrates two requesters and drives the SPI peripheral
// register port byte by byte while holding slave select for the whole burst.
module spi_burst_sequencer
    import spi_seq_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 4095,
    parameter int TMO_W   = 12
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [1:0]         iReq,
    input  logic [7:0]         iReqSS,
    input  logic [2*LEN_W-1:0] iReqLen,
    output logic [1:0]         oGnt,
    input  logic               iTxValid,
    input  logic [7:0]         iTxData,
    output logic               oTxReady,
    output logic               oRxValid,
    output logic [7:0]         oRxData,
    input  logic               iRxReady,
    output logic               oDone,
    output logic               oErr,
    output logic [1:0]         oAddr,
    output logic [15:0]        oWData,
    input  logic [15:0]        iRData,
    output logic               oWrite,
    output logic               oEnable
);

    state_t            state;
    logic [3:0]        ss;
    logic [LEN_W-1:0]  count;
    logic [TMO_W-1:0]  tmo;
    logic [1:0]        arb_gnt;
    logic              arb_adv;
    logic              unused_rdata;

    // Upper half of the read bus carries nothing this block needs
    assign unused_rdata = ^iRData[15:8];

    assign arb_adv  = (state == ST_IDLE);
    assign oTxReady = (state == ST_WAIT_TX) && iTxValid;

    rr_arb2 u_arb (
        .clk     (iClk),
        .rst     (iRst),
        .req     (iReq),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    // Burst sequencer; bus outputs are loaded on entry to the state that owns them
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= ST_IDLE;
            oGnt     <= 2'b00;
            ss       <= '0;
            count    <= '0;
            tmo      <= '0;
            oRxValid <= 1'b0;
            oRxData  <= '0;
            oDone    <= 1'b0;
            oErr     <= 1'b0;
            oAddr    <= ADDR_CTRL;
            oWData   <= '0;
            oWrite   <= 1'b0;
            oEnable  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            oErr  <= 1'b0;
            case (state)
                ST_IDLE: if (|iReq) begin
                    oGnt  <= arb_gnt;
                    ss    <= arb_gnt[1] ? iReqSS[7:4] : iReqSS[3:0];
                    count <= arb_gnt[1] ? iReqLen[2*LEN_W-1:LEN_W] : iReqLen[LEN_W-1:0];
                    state <= ST_GRANT;
                end
                ST_GRANT: state <= ST_WAIT_TX;
                ST_WAIT_TX: if (iTxValid) begin
                    oEnable <= 1'b1;
                    oWrite  <= 1'b1;
                    oAddr   <= ADDR_TXD;
                    oWData  <= {8'h00, iTxData};
                    state   <= ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    oAddr  <= ADDR_CTRL;
                    oWData <= ctrl_word(ss);
                    tmo    <= '0;
                    state  <= ST_WR_CTRL;
                end
                ST_WR_CTRL: begin
                    oWrite <= 1'b0;
                    oWData <= '0;
                    state  <= ST_POLL;
                end
                ST_POLL: begin
                    if (!iRData[BUSY_BIT]) begin
                        oAddr <= ADDR_RXD;
                        state <= ST_RD_DATA;
                    end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                        // Give up: drop SS and flag the abort in the release cycle
                        oWrite <= 1'b1;
                        oWData <= '0;
                        oErr   <= 1'b1;
                        state  <= ST_RELEASE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    oRxData  <= iRData[7:0];
                    oRxValid <= 1'b1;
                    oEnable  <= 1'b0;
                    oAddr    <= ADDR_CTRL;
                    state    <= ST_RX;
                end
                ST_RX: if (iRxReady) begin
                    oRxValid <= 1'b0;
                    if (count == '0) begin
                        oEnable <= 1'b1;
                        oWrite  <= 1'b1;
                        oAddr   <= ADDR_CTRL;
                        oWData  <= '0;
                        oDone   <= 1'b1;
                        state   <= ST_RELEASE;
                    end else begin
                        count <= count - 1'b1;
                        state <= ST_WAIT_TX;
                    end
                end
                ST_RELEASE: begin
                    oGnt    <= 2'b00;
                    oEnable <= 1'b0;
                    oWrite  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Self-checking bench: peripheral model with programmable busy length, a
// write scoreboard on the register port, and table-driven bursts.
module tb_spi_burst_sequencer;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [1:0]  iReq = 2'b00;
    logic [7:0]  iReqSS = 8'h00;
    logic [15:0] iReqLen = 16'h0000;
    logic [1:0]  oGnt;
    logic        iTxValid = 1'b0;
    logic [7:0]  iTxData = 8'h00;
    logic        oTxReady;
    logic        oRxValid;
    logic [7:0]  oRxData;
    logic        iRxReady = 1'b0;
    logic        oDone;
    logic        oErr;
    logic [1:0]  oAddr;
    logic [15:0] oWData;
    logic [15:0] iRData;
    logic        oWrite;
    logic        oEnable;

    int n_chk = 0;
    int n_fail = 0;

    // Peripheral model state
    int         busy_len = 1;
    int         poll_cnt;
    int         polls_seen = 0;
    int         hs = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       busy;
    logic [17:0] wq[$];

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  ss;
        logic [15:0] len;
        int          busy;
        logic [7:0]  tx;
        logic [7:0]  rx;
        int          stall;
        logic [1:0]  exp_gnt;
    } vec_t;

    vec_t tbl[7];

    spi_burst_sequencer dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iReqSS(iReqSS), .iReqLen(iReqLen),
        .oGnt(oGnt), .iTxValid(iTxValid), .iTxData(iTxData), .oTxReady(oTxReady),
        .oRxValid(oRxValid), .oRxData(oRxData), .iRxReady(iRxReady), .oDone(oDone),
        .oErr(oErr), .oAddr(oAddr), .oWData(oWData), .iRData(iRData), .oWrite(oWrite),
        .oEnable(oEnable)
    );

    always #5 iClk = ~iClk;

    // Busy reads 1 for the first busy_len-1 polls after a GO write, then 0
    assign busy = (poll_cnt + 1 < busy_len);
    assign iRData = (oEnable && !oWrite && oAddr == 2'd2) ? {8'h00, rx_byte} :
                    (oEnable && !oWrite && oAddr == 2'd0) ? {8'h00, busy, 7'h00} : 16'h0000;

    always @(posedge iClk or posedge iRst) begin
        if (iRst)
            poll_cnt <= 0;
        else if (oEnable && oWrite && oAddr == 2'd0 && oWData[7])
            poll_cnt <= 0;
        else if (oEnable && !oWrite && oAddr == 2'd0)
            poll_cnt <= poll_cnt + 1;
    end

    always @(posedge iClk) begin
        if (!iRst && oRxValid && iRxReady) hs <= hs + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard of register writes; also counts polls since the last GO write
    always @(negedge iClk) begin
        if (!iRst && oEnable) begin
            if (oWrite) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL bus_write: got %h expected no write", {oAddr, oWData});
                end else begin
                    check("bus_write", 32'({oAddr, oWData}), 32'(wq.pop_front()));
                end
                if (oAddr == 2'd0 && oWData[7]) polls_seen = 0;
            end else if (oAddr == 2'd0) begin
                polls_seen++;
            end
        end
    end

    task automatic wait_gnt();
        int cyc = 0;
        while (oGnt == 2'b00 && cyc < 20) begin @(negedge iClk); cyc++; end
    endtask

    task automatic send_tx(input logic [7:0] b);
        int cyc = 0;
        iTxValid = 1'b1;
        iTxData  = b;
        #1;
        while (!oTxReady && cyc < 20) begin @(negedge iClk); #1; cyc++; end
        check("tx_ready", 32'(oTxReady), 32'd1);
        @(negedge iClk);
        iTxValid = 1'b0;
        iTxData  = 8'h00;
    endtask

    task automatic do_burst(input vec_t v);
        int cyc, nb, hs0;
        logic [3:0] ssv;
        logic [7:0] txb;
        logic bad;
        @(negedge iClk);
        iReq = v.req; iReqSS = v.ss; iReqLen = v.len;
        wait_gnt();
        check("grant", 32'(oGnt), 32'(v.exp_gnt));
        // Changes after the grant must not affect the running burst
        iReq = 2'b00; iReqSS = 8'hFF; iReqLen = 16'hFFFF;
        ssv = v.exp_gnt[1] ? v.ss[7:4] : v.ss[3:0];
        nb  = 1 + int'(v.exp_gnt[1] ? v.len[15:8] : v.len[7:0]);
        busy_len = v.busy;
        hs0 = hs;
        for (int b = 0; b < nb; b++) begin
            txb = v.tx + 8'(b);
            rx_byte = v.rx ^ 8'(b);
            wq.push_back({2'd1, 8'h00, txb});
            wq.push_back({2'd0, 8'h00, 1'b1, ssv, 3'b000});
            send_tx(txb);
            cyc = 0;
            while (!oRxValid && cyc < v.busy + 20) begin @(negedge iClk); cyc++; end
            check("rx_valid", 32'(oRxValid), 32'd1);
            check("poll_count", 32'(polls_seen), 32'(v.busy));
            check("rx_data", 32'(oRxData), 32'(rx_byte));
            bad = 1'b0;
            for (int s = 0; s < v.stall; s++) begin
                @(negedge iClk);
                if (oRxValid !== 1'b1 || oRxData !== rx_byte || oEnable !== 1'b0) bad = 1'b1;
            end
            if (v.stall > 0) check("rx_stall", 32'(bad), 32'd0);
            if (b == nb - 1) wq.push_back(18'h0);
            iRxReady = 1'b1;
            @(negedge iClk);
            iRxReady = 1'b0;
        end
        check("done_err", 32'({oDone, oErr}), 32'b10);
        check("gnt_held", 32'(oGnt), 32'(v.exp_gnt));
        check("handshakes", 32'(hs - hs0), 32'(nb));
        @(negedge iClk);
        check("after_release", 32'({oDone, oErr, oGnt}), 32'd0);
    endtask

    initial begin
        int cyc;
        logic done_seen;
        vec_t tie;

        //           req    ss     len       busy tx     rx     stall gnt
        tbl[0] = '{2'b11, 8'h81, 16'h0100,  1, 8'h11, 8'h21,  0, 2'b01};
        tbl[1] = '{2'b11, 8'h81, 16'h0100,  1, 8'h12, 8'h22,  0, 2'b10};
        tbl[2] = '{2'b11, 8'h81, 16'h0100,  1, 8'h13, 8'h23,  0, 2'b01};
        tbl[3] = '{2'b01, 8'h02, 16'h0000, 10, 8'hA5, 8'h3C,  0, 2'b01};
        tbl[4] = '{2'b10, 8'h40, 16'h0300,  2, 8'h10, 8'h80,  0, 2'b10};
        tbl[5] = '{2'b01, 8'h04, 16'h0001,  3, 8'h55, 8'h66, 20, 2'b01};
        tbl[6] = '{2'b11, 8'h21, 16'h0005,  1, 8'h77, 8'h99,  0, 2'b10};

        // Reset state
        repeat (3) @(negedge iClk);
        check("reset_ctl", 32'({oGnt, oTxReady, oRxValid, oDone, oErr, oAddr, oWrite, oEnable}), 32'd0);
        check("reset_data", 32'({oRxData, oWData}), 32'd0);
        iRst = 1'b0;

        foreach (tbl[i]) do_burst(tbl[i]);

        // Poll timeout: busy never clears
        @(negedge iClk);
        iReq = 2'b01; iReqSS = 8'h08; iReqLen = 16'h0000;
        wait_gnt();
        check("tmo_grant", 32'(oGnt), 32'b01);
        iReq = 2'b00;
        busy_len = 100000;
        wq.push_back({2'd1, 16'h005A});
        wq.push_back({2'd0, 16'h00C0});
        wq.push_back(18'h0);
        send_tx(8'h5A);
        cyc = 0;
        done_seen = 1'b0;
        while (!oErr && cyc < 5000) begin
            @(negedge iClk);
            if (oDone) done_seen = 1'b1;
            cyc++;
        end
        check("tmo_err", 32'({oDone, oErr}), 32'b01);
        check("tmo_polls", 32'(polls_seen), 32'd4095);
        check("tmo_no_done", 32'(done_seen), 32'd0);
        @(negedge iClk);
        check("tmo_after", 32'({oErr, oGnt, oRxValid}), 32'd0);

        // Reset asserted while polling
        @(negedge iClk);
        iReq = 2'b10; iReqSS = 8'h10; iReqLen = 16'h0000;
        wait_gnt();
        check("rst_grant", 32'(oGnt), 32'b10);
        iReq = 2'b00;
        busy_len = 100;
        wq.push_back({2'd1, 16'h00C3});
        wq.push_back({2'd0, 16'h0088});
        send_tx(8'hC3);
        cyc = 0;
        while (!(oEnable && !oWrite && oAddr == 2'd0) && cyc < 20) begin @(negedge iClk); cyc++; end
        check("rst_in_poll", 32'({oEnable, oWrite, oAddr}), 32'b1000);
        #2 iRst = 1'b1;
        #1;
        check("rst_async_ctl", 32'({oGnt, oTxReady, oRxValid, oDone, oErr, oAddr, oWrite, oEnable}), 32'd0);
        check("rst_async_data", 32'({oRxData, oWData}), 32'd0);
        wq.delete();
        @(negedge iClk);
        iRst = 1'b0;

        // Arbitration pointer is back at its reset value
        tie = tbl[0];
        do_burst(tie);
        check("queue_empty", 32'(wq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
